// File: rtl/uart_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_program_loader
// Description : Decodes host command bytes from the UART receiver. It can
//               stream a program into instruction memory as 32-bit words,
//               start or pause the pipeline, or issue single-step pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_program_loader #(
    parameter int MEM_DEPTH = 256,
    parameter int TIMEOUT   = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        instr_we,
    output logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    output logic        load_done,
    output logic        mips_enable,
    output logic        step_pulse,
    output logic        cmd_error
);

    localparam int          c_TW       = ($clog2(TIMEOUT + 1) > 20) ? $clog2(TIMEOUT + 1) : 20;
    localparam logic [c_TW-1:0] c_TIMEOUT = c_TW'(TIMEOUT);
    localparam logic [31:0] c_LAST_IDX = 32'(MEM_DEPTH - 1);

    localparam logic [1:0]  c_S_IDLE   = 2'd0;
    localparam logic [1:0]  c_S_LOAD   = 2'd1;
    localparam logic [1:0]  c_S_RUN    = 2'd2;

    localparam logic [7:0]  c_CMD_LOAD  = 8'h4C;
    localparam logic [7:0]  c_CMD_RUN   = 8'h52;
    localparam logic [7:0]  c_CMD_STEP  = 8'h53;
    localparam logic [7:0]  c_CMD_PAUSE = 8'h50;

    logic [1:0]      r_state;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_word;
    logic [31:0]     r_index;
    logic [c_TW-1:0] r_timer;
    logic            r_instr_we;
    logic [31:0]     r_instr_addr;
    logic [31:0]     r_instr_data;
    logic            r_load_done;
    logic            r_mips_enable;
    logic            r_step_pulse;
    logic            r_cmd_error;

    logic [31:0]     w_word_next;
    logic            w_last_word;

    assign w_word_next = {r_word[23:0], rx_data};
    // A HALT word or the final memory slot ends the program.
    assign w_last_word = (w_word_next == 32'd0) || (r_index == c_LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_S_IDLE;
            r_byte_cnt    <= 2'd0;
            r_word        <= 32'd0;
            r_index       <= 32'd0;
            r_timer       <= '0;
            r_instr_we    <= 1'b0;
            r_instr_addr  <= 32'd0;
            r_instr_data  <= 32'd0;
            r_load_done   <= 1'b0;
            r_mips_enable <= 1'b0;
            r_step_pulse  <= 1'b0;
            r_cmd_error   <= 1'b0;
        end else begin
            r_instr_we   <= 1'b0;
            r_step_pulse <= 1'b0;
            r_cmd_error  <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            c_CMD_LOAD: begin
                                r_load_done  <= 1'b0;
                                r_index      <= 32'd0;
                                r_instr_addr <= 32'd0;
                                r_byte_cnt   <= 2'd0;
                                r_word       <= 32'd0;
                                r_timer      <= '0;
                                r_state      <= c_S_LOAD;
                            end
                            c_CMD_RUN: begin
                                if (r_load_done) begin
                                    r_mips_enable <= 1'b1;
                                    r_state       <= c_S_RUN;
                                end else begin
                                    r_cmd_error <= 1'b1;
                                end
                            end
                            c_CMD_STEP: begin
                                if (r_load_done) r_step_pulse <= 1'b1;
                                else             r_cmd_error  <= 1'b1;
                            end
                            default: r_cmd_error <= 1'b1;
                        endcase
                    end
                end
                c_S_LOAD: begin
                    if (rx_valid) begin
                        r_timer <= '0;
                        if (r_byte_cnt == 2'd3) begin
                            r_instr_we   <= 1'b1;
                            r_instr_addr <= r_index;
                            r_instr_data <= w_word_next;
                            r_byte_cnt   <= 2'd0;
                            r_word       <= 32'd0;
                            if (w_last_word) begin
                                r_load_done <= 1'b1;
                                r_state     <= c_S_IDLE;
                            end else begin
                                r_index <= r_index + 32'd1;
                            end
                        end else begin
                            r_word     <= w_word_next;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end else if (r_timer == c_TIMEOUT) begin
                        // Host went silent: drop any partial word and give up the load.
                        r_cmd_error <= 1'b1;
                        r_byte_cnt  <= 2'd0;
                        r_word      <= 32'd0;
                        r_timer     <= '0;
                        r_state     <= c_S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_S_RUN: begin
                    if (rx_valid && (rx_data == c_CMD_PAUSE)) begin
                        r_mips_enable <= 1'b0;
                        r_state       <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign instr_we    = r_instr_we;
    assign instr_addr  = r_instr_addr;
    assign instr_data  = r_instr_data;
    assign load_done   = r_load_done;
    assign mips_enable = r_mips_enable;
    assign step_pulse  = r_step_pulse;
    assign cmd_error   = r_cmd_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_program_loader
// Description : Scoreboard bench for uart_program_loader with a byte-level
//               protocol model and randomized command/data traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_program_loader;

    localparam int c_DEPTH = 4;
    localparam int c_TO    = 16;

    localparam int c_EV_WR   = 0;
    localparam int c_EV_ERR  = 1;
    localparam int c_EV_STEP = 2;
    localparam int c_EV_RISE = 3;
    localparam int c_EV_FALL = 4;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ld;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        instr_we;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        load_done;
    logic        mips_enable;
    logic        step_pulse;
    logic        cmd_error;

    uart_program_loader #(
        .MEM_DEPTH (c_DEPTH),
        .TIMEOUT   (c_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .instr_we    (instr_we),
        .instr_addr  (instr_addr),
        .instr_data  (instr_data),
        .load_done   (load_done),
        .mips_enable (mips_enable),
        .step_pulse  (step_pulse),
        .cmd_error   (cmd_error)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_pass   = 0;
    ev_t exp_q[$];

    // Reference model: protocol state at the level of whole bytes and words.
    int        m_state = 0;  // 0 idle, 1 load, 2 run
    bit        m_done  = 1'b0;
    int        m_idx   = 0;
    int        m_idle  = 0;
    logic [7:0] m_pend[$];

    task automatic check(input string name, input bit ok, input logic [68:0] act, input logic [68:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic push_ev(input int kind, input logic [31:0] addr, input logic [31:0] data, input logic ld);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.ld = ld;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [31:0] w;
        bit          last;
        m_idle = 0;
        if (m_state == 0) begin
            if (b == 8'h4C) begin
                m_done = 1'b0; m_idx = 0; m_pend.delete(); m_state = 1;
            end else if (b == 8'h52 && m_done) begin
                push_ev(c_EV_RISE, 0, 0, 0); m_state = 2;
            end else if (b == 8'h53 && m_done) begin
                push_ev(c_EV_STEP, 0, 0, 0);
            end else begin
                push_ev(c_EV_ERR, 0, 0, 0);
            end
        end else if (m_state == 1) begin
            m_pend.push_back(b);
            if (m_pend.size() == 4) begin
                w = {m_pend[0], m_pend[1], m_pend[2], m_pend[3]};
                m_pend.delete();
                last = (w == 32'd0) || (m_idx == c_DEPTH - 1);
                push_ev(c_EV_WR, 32'(m_idx), w, last);
                if (last) begin
                    m_done = 1'b1; m_state = 0;
                end else begin
                    m_idx++;
                end
            end
        end else if (b == 8'h50) begin
            push_ev(c_EV_FALL, 0, 0, 0); m_state = 0;
        end
    endtask

    task automatic model_idle(input int n);
        m_idle += n;
        if (m_state == 1 && m_idle > c_TO) begin
            push_ev(c_EV_ERR, 0, 0, 0);
            m_pend.delete();
            m_state = 0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        model_idle(n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
    endtask

    task automatic check_all_zero(input string name);
        logic [68:0] v;
        v = {instr_we, instr_addr, instr_data, load_done, mips_enable, step_pulse, cmd_error};
        check(name, v == 69'd0, v, 69'd0);
    endtask

    // Monitor: every DUT output event must match the head of the queue.
    logic        prev_en   = 1'b0;
    logic [31:0] hold_data = 32'd0;
    ev_t         mon_ev;

    task automatic pop_expect(input int kind, input string name, output bit ok);
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            check({name, "_unexpected"}, 1'b0, 69'(kind), 69'hFF);
        end else begin
            mon_ev = exp_q.pop_front();
            check({name, "_kind"}, mon_ev.kind == kind, 69'(kind), 69'(mon_ev.kind));
            ok = (mon_ev.kind == kind);
        end
    endtask

    always @(negedge clk) begin
        bit ok;
        if (!rst) begin
            prev_en   = 1'b0;
            hold_data = 32'd0;
        end else begin
            check("step_and_enable_exclusive", !(step_pulse && mips_enable),
                  69'({step_pulse, mips_enable}), 69'd0);
            if (instr_we) begin
                pop_expect(c_EV_WR, "write", ok);
                if (ok) begin
                    check("write_addr", instr_addr == mon_ev.addr, 69'(instr_addr), 69'(mon_ev.addr));
                    check("write_data", instr_data == mon_ev.data, 69'(instr_data), 69'(mon_ev.data));
                    check("write_load_done", load_done == mon_ev.ld, 69'(load_done), 69'(mon_ev.ld));
                    hold_data = mon_ev.data;
                end
            end else if (instr_data != hold_data) begin
                check("data_hold", 1'b0, 69'(instr_data), 69'(hold_data));
            end
            if (cmd_error)  pop_expect(c_EV_ERR, "cmd_error", ok);
            if (step_pulse) pop_expect(c_EV_STEP, "step", ok);
            if (mips_enable && !prev_en) pop_expect(c_EV_RISE, "enable_rise", ok);
            if (!mips_enable && prev_en) pop_expect(c_EV_FALL, "enable_fall", ok);
            prev_en = mips_enable;
        end
    end

    initial begin
        int r;
        logic [7:0] b;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b1;

        // Step and run are refused before any program is resident
        send(8'h53);
        send(8'h52);
        idle(2);

        // Load then halt
        send(8'h4C);
        send_word(32'h12345678);
        send_word(32'h00000000);
        idle(2);
        check("load_done_after_halt", load_done == 1'b1, 69'(load_done), 69'd1);

        // Run / ignored byte / pause, then stepping
        send(8'h52); idle(1);
        send(8'h58); idle(1);
        send(8'h50); idle(1);
        send(8'h53);
        send(8'h53);
        idle(2);

        // Partial word followed by silence aborts the load
        send(8'h4C);
        send(8'hAA);
        send(8'hBB);
        idle(20);
        check("load_done_after_timeout", load_done == 1'b0, 69'(load_done), 69'd0);
        send(8'h52);
        idle(2);

        // Idle exactly at the limit is still tolerated
        send(8'h4C);
        send(8'h01);
        idle(c_TO);
        send(8'h02); send(8'h03); send(8'h04);
        idle(c_TO + 1);

        // Depth limit with back-to-back bytes; fifth word lands in IDLE
        send(8'h4C);
        for (int i = 0; i < 5; i++) send_word($urandom | 32'h0100_0000);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (m_state == 1) begin
                b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end else begin
                case ($urandom_range(0, 5))
                    0: b = 8'h4C;
                    1: b = 8'h52;
                    2: b = 8'h53;
                    3: b = 8'h50;
                    default: b = 8'($urandom);
                endcase
            end
            send(b);
            if (r == 6)      idle(1);
            else if (r == 7) idle(2);
            else if (r == 8) idle(c_TO);
            else if (r == 9) idle(c_TO + 4);
        end
        idle(c_TO + 4);
        if (m_state == 2) begin
            send(8'h50);
            idle(2);
        end

        // Reset in the middle of the second word
        send(8'h4C);
        send_word(32'h11223344);
        send(8'h55);
        send(8'h66);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        check("queue_drained_at_reset", exp_q.size() == 0, 69'(exp_q.size()), 69'd0);
        exp_q.delete();
        m_state = 0; m_done = 1'b0; m_idx = 0; m_idle = 0; m_pend.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        send(8'h4C);
        send_word(32'hCAFEF00D);
        send_word(32'h00000000);
        idle(4);

        check("queue_drained_at_end", exp_q.size() == 0, 69'(exp_q.size()), 69'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
